// File: rtl/rsa256_pkg.sv
// Shared constants and state encoding for the RSA256 stream host.
package rsa256_pkg;
  localparam int KEY_W     = 256;
  localparam int IN_BYTES  = KEY_W / 8;
  localparam int OUT_BYTES = KEY_W / 8 - 1;
  localparam int CNT_W     = $clog2(IN_BYTES);

  typedef enum logic [2:0] {
    S_GET_N,
    S_GET_D,
    S_GET_A,
    S_START,
    S_WAIT,
    S_SEND
  } host_state_e;
endpackage

// File: rtl/rsa256_stream_host_if.sv
// Byte stream, plaintext stream and RSA core handshake bundle.
// The master modport is the host's view; slave is the surrounding environment.
interface rsa256_stream_host_if;
  import rsa256_pkg::*;

  logic [7:0]       i_rx_data;
  logic             i_rx_valid;
  logic             o_rx_ready;
  logic [7:0]       o_tx_data;
  logic             o_tx_valid;
  logic             i_tx_ready;
  logic             i_rekey;
  logic             o_core_start;
  logic [KEY_W-1:0] o_core_a;
  logic [KEY_W-1:0] o_core_d;
  logic [KEY_W-1:0] o_core_n;
  logic [KEY_W-1:0] i_core_result;
  logic             i_core_finished;
  logic             o_busy;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_rekey, i_core_result, i_core_finished,
    output o_rx_ready, o_tx_data, o_tx_valid, o_core_start, o_core_a, o_core_d, o_core_n,
           o_busy
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_ready, i_rekey, i_core_result, i_core_finished,
    input  o_rx_ready, o_tx_data, o_tx_valid, o_core_start, o_core_a, o_core_d, o_core_n,
           o_busy
  );
endinterface

// File: rtl/rsa256_stream_host.sv
// Host for the RSA256 core: loads n and d once, then for every received cipher block
// starts the core and streams the plaintext back out byte by byte.
//
//  state   | meaning
//  S_GET_N | shifting in modulus bytes
//  S_GET_D | shifting in private exponent bytes
//  S_GET_A | shifting in cipher block bytes; rekey accepted only before the first byte
//  S_START | one-cycle start pulse to the core
//  S_WAIT  | waiting for the core to finish
//  S_SEND  | emitting the plaintext bytes, top result byte dropped
module rsa256_stream_host
  import rsa256_pkg::*;
(
  input logic                  i_clk,
  input logic                  i_rst,
  rsa256_stream_host_if.master bus
);
  host_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [KEY_W-1:0] n_q, d_q, a_q;
  logic [KEY_W-9:0] out_q;
  logic             start_q, tx_valid_q, busy_q;

  logic in_get, rekey_ok, rx_ready, rx_fire, last_in, last_out;
  // the result's top byte never leaves the block
  logic unused_res_top;

  assign unused_res_top = ^bus.i_core_result[KEY_W-1:KEY_W-8];

  assign in_get   = (state_q == S_GET_N) || (state_q == S_GET_D) || (state_q == S_GET_A);
  // a rekey request takes priority over a byte offered in the same cycle
  assign rekey_ok = (state_q == S_GET_A) && (cnt_q == '0) && bus.i_rekey;
  assign rx_ready = in_get && !rekey_ok;
  assign rx_fire  = rx_ready && bus.i_rx_valid;
  assign last_in  = (cnt_q == CNT_W'(IN_BYTES - 1));
  assign last_out = (cnt_q == CNT_W'(OUT_BYTES - 1));

  assign bus.o_rx_ready   = rx_ready;
  assign bus.o_tx_data    = out_q[KEY_W-9 -: 8];
  assign bus.o_tx_valid   = tx_valid_q;
  assign bus.o_core_start = start_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_core_a     = a_q;
  assign bus.o_core_d     = d_q;
  assign bus.o_core_n     = n_q;

  // sequencing FSM with operand shift registers and registered handshake outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_GET_N;
      cnt_q      <= '0;
      n_q        <= '0;
      d_q        <= '0;
      a_q        <= '0;
      out_q      <= '0;
      start_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_GET_N: if (rx_fire) begin
          n_q <= {n_q[KEY_W-9:0], bus.i_rx_data};
          if (last_in) begin
            state_q <= S_GET_D;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
        S_GET_D: if (rx_fire) begin
          d_q <= {d_q[KEY_W-9:0], bus.i_rx_data};
          if (last_in) begin
            state_q <= S_GET_A;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
        S_GET_A: begin
          if (rekey_ok) begin
            state_q <= S_GET_N;
            cnt_q   <= '0;
          end else if (rx_fire) begin
            a_q <= {a_q[KEY_W-9:0], bus.i_rx_data};
            if (last_in) begin
              state_q <= S_START;
              start_q <= 1'b1;
              cnt_q   <= '0;
            end else cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_START: begin
          start_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: if (bus.i_core_finished) begin
          out_q      <= bus.i_core_result[KEY_W-9:0];
          tx_valid_q <= 1'b1;
          state_q    <= S_SEND;
          cnt_q      <= '0;
        end
        S_SEND: if (bus.i_tx_ready) begin
          out_q <= {out_q[KEY_W-17:0], 8'h00};
          if (last_out) begin
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= S_GET_A;
            cnt_q      <= '0;
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
        default: begin
          state_q <= S_GET_N;
          cnt_q   <= '0;
        end
      endcase
    end
  end
endmodule
